// File: rtl/avmm_arbiter_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
// Holds the arbiter state encoding and the grant-index width rule.
package avmm_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } t_arb_states;

   // Index width for n requesters, never below one bit.
   function automatic int f_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/avmm_rr_select.sv
// Combinational round-robin find-first: returns the first requester after ptr_i,
// wrapping modulo P_NUM_REQ, plus a flag that any request is present.
module avmm_rr_select
   import avmm_arbiter_pkg::*;
#(
   parameter int P_NUM_REQ = 4
)
(
   input  logic [P_NUM_REQ-1:0]                  req_i,
   input  logic [f_idx_width(P_NUM_REQ)-1:0]     ptr_i,
   output logic [f_idx_width(P_NUM_REQ)-1:0]     winner_o,
   output logic                                  any_req_o
);

   localparam int IW = f_idx_width(P_NUM_REQ);

   always_comb begin
      int cand;
      winner_o  = '0;
      any_req_o = 1'b0;
      cand      = 0;
      // Walk ptr+1 .. ptr+N so the last winner has lowest priority.
      for (int k = 1; k <= P_NUM_REQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= P_NUM_REQ) begin
            cand = cand - P_NUM_REQ;
         end
         if (!any_req_o && req_i[cand[IW-1:0]]) begin
            any_req_o = 1'b1;
            winner_o  = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among P_NUM_REQ requesters,
// with per-requester lock and a waitrequest watchdog.
module avmm_rr_arbiter
   import avmm_arbiter_pkg::*;
#(
   parameter int P_NUM_REQ  = 4,
   parameter int P_ADDRSIZE = 8,
   parameter int P_DATASIZE = 32,
   parameter int P_TIMEOUT  = 1024
)
(
   input  logic                                CLOCK,
   input  logic                                RESET_N,
   input  logic [P_NUM_REQ-1:0]                REQ_READ,
   input  logic [P_NUM_REQ-1:0]                REQ_WRITE,
   input  logic [P_NUM_REQ-1:0]                REQ_LOCK,
   input  logic [P_NUM_REQ*P_ADDRSIZE-1:0]     REQ_ADDRESS,
   input  logic [P_NUM_REQ*P_DATASIZE-1:0]     REQ_WRITEDATA,
   output logic [P_NUM_REQ-1:0]                REQ_WAITREQUEST,
   output logic [P_DATASIZE-1:0]               REQ_READDATA,
   output logic                                AVM_M0_READ,
   output logic                                AVM_M0_WRITE,
   input  logic                                AVM_M0_WAITREQUEST,
   output logic [P_ADDRSIZE-1:0]               AVM_M0_ADDRESS,
   input  logic [P_DATASIZE-1:0]               AVM_M0_READDATA,
   output logic [P_DATASIZE-1:0]               AVM_M0_WRITEDATA,
   output logic [f_idx_width(P_NUM_REQ)-1:0]   GRANT_IDX,
   output logic                                TIMEOUT_ERR
);

   localparam int IW = f_idx_width(P_NUM_REQ);
   localparam int CW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WD_LAST = (P_TIMEOUT > 0) ? CW'(P_TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] WD_MAX  = '1;

   t_arb_states           state_q, state_d;
   logic [IW-1:0]         grant_q, grant_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [CW-1:0]         wdog_q, wdog_d;
   logic                  terr_q, terr_d;
   logic [P_NUM_REQ-1:0]  req;
   logic [IW-1:0]         win;
   logic                  any_req;

   assign req          = REQ_READ | REQ_WRITE;
   assign GRANT_IDX    = grant_q;
   assign TIMEOUT_ERR  = terr_q;
   assign REQ_READDATA = AVM_M0_READDATA;

   avmm_rr_select #(
      .P_NUM_REQ (P_NUM_REQ)
   ) u_select (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .winner_o  (win),
      .any_req_o (any_req)
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= IW'(P_NUM_REQ - 1);
         wdog_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         wdog_q  <= wdog_d;
         terr_q  <= terr_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      ptr_d            = ptr_q;
      wdog_d           = wdog_q;
      terr_d           = terr_q;
      AVM_M0_READ      = 1'b0;
      AVM_M0_WRITE     = 1'b0;
      AVM_M0_ADDRESS   = '0;
      AVM_M0_WRITEDATA = '0;
      REQ_WAITREQUEST  = '1;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = win;
               ptr_d   = win;
               wdog_d  = '0;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            // Read wins when a requester raises both strobes.
            AVM_M0_READ      = REQ_READ[grant_q];
            AVM_M0_WRITE     = REQ_WRITE[grant_q] & ~REQ_READ[grant_q];
            AVM_M0_ADDRESS   = REQ_ADDRESS[grant_q*P_ADDRSIZE +: P_ADDRSIZE];
            AVM_M0_WRITEDATA = REQ_WRITEDATA[grant_q*P_DATASIZE +: P_DATASIZE];
            REQ_WAITREQUEST[grant_q] = AVM_M0_WAITREQUEST;

            if (!req[grant_q]) begin
               state_d = ST_IDLE;
            end else if (!AVM_M0_WAITREQUEST) begin
               if (REQ_LOCK[grant_q]) begin
                  wdog_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (P_TIMEOUT > 0) begin
               // Forced release keeps the requester's waitrequest high.
               if (wdog_q == WD_LAST) begin
                  terr_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (wdog_q != WD_MAX) begin
                  wdog_d = wdog_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
